// File: rtl/cpu_spi_mem_responder_pkg.sv
// Shared constants, FSM encoding and frame builder for the CPU-to-SPI-SRAM responder.
package cpu_spi_mem_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         FRAME_BITS    = 40;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One complete SRAM transaction, MSB first: command, byte address, data.
    // Word addresses become byte addresses by appending a zero LSB.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        wr,
        input logic [11:0] addr,
        input logic [15:0] wdata
    );
        return {(wr ? SPI_CMD_WRITE : SPI_CMD_READ),
                3'b000, addr, 1'b0,
                (wr ? wdata : 16'h0000)};
    endfunction

endpackage

// File: rtl/cpu_spi_mem_responder_if.sv
// CPU memory bus as seen by the responder: request side from the CPU, data and hold back to it.
interface cpu_spi_mem_responder_if;

    logic        en;
    logic        rdwr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        hold;

    modport master (
        output en, rdwr, addr, wdata,
        input  rdata, hold
    );

    modport slave (
        input  en, rdwr, addr, wdata,
        output rdata, hold
    );

endinterface

// File: rtl/cpu_spi_mem_responder_shift40.sv
// 40-bit SPI mode-0 shifter: SCLK divider, bit counter, MOSI shift and MISO capture.
module spi_shift40
    import cpu_spi_mem_pkg::*;
#(
    parameter int SCK_HALF = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  start_i,
    input  logic                  miso_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic [15:0]           rdata_o
);

    logic                  busy_q;
    logic                  sclk_q;
    logic [3:0]            div_q;
    logic [5:0]            bit_q;
    logic [FRAME_BITS-1:0] sh_q;
    logic [15:0]           cap_q;
    logic                  half_end;

    assign half_end = (div_q == 4'(SCK_HALF - 1));

    // Half-period divider, SCLK phase and bit counter; a bit ends on the SCLK fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            sclk_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
        end else if (busy_q) begin
            if (half_end) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    bit_q <= bit_q + 6'd1;
                    if (bit_q == 6'(FRAME_BITS - 1)) begin
                        busy_q <= 1'b0;
                    end
                end
            end else begin
                div_q <= div_q + 4'd1;
            end
        end
    end

    // MOSI advances as SCLK falls, MISO is captured as SCLK rises.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            sh_q <= frame_i;
        end else if (busy_q && half_end && sclk_q) begin
            sh_q <= {sh_q[FRAME_BITS-2:0], 1'b0};
        end
        if (busy_q && half_end && !sclk_q) begin
            cap_q <= {cap_q[14:0], miso_i};
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = busy_q && half_end && sclk_q && (bit_q == 6'(FRAME_BITS - 1));
    assign sclk_o  = sclk_q;
    assign mosi_o  = sh_q[FRAME_BITS-1];
    assign rdata_o = cap_q;

endmodule

// File: rtl/cpu_spi_mem_responder.sv
// Serves each CPU word access with one SPI frame to a serial SRAM, freezing the CPU meanwhile.
module cpu_spi_mem_responder
    import cpu_spi_mem_pkg::*;
#(
    parameter int SCK_HALF = 1
) (
    input  logic                    clkin,
    input  logic                    rst,
    cpu_spi_mem_responder_if.slave  cpu,
    output logic                    spi_cs_n,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    state_t      state_q, state_d;
    logic        served_q;
    logic        wr_q;
    logic [15:0] rdata_q;

    logic        accept;
    logic        load;
    logic        start;
    logic        frame_act;
    logic        shift_busy;
    logic        shift_done;
    logic        shift_mosi;
    logic [15:0] shift_rdata;

    // A request is new only if its previous step has not just been served.
    assign accept = cpu.en && !served_q;

    spi_shift40 #(
        .SCK_HALF (SCK_HALF)
    ) u_shift (
        .clk_i   (clkin),
        .rst_i   (rst),
        .load_i  (load),
        .frame_i (build_frame(cpu.rdwr, cpu.addr, cpu.wdata)),
        .start_i (start),
        .miso_i  (spi_miso),
        .busy_o  (shift_busy),
        .done_o  (shift_done),
        .sclk_o  (spi_sclk),
        .mosi_o  (shift_mosi),
        .rdata_o (shift_rdata)
    );

    // State register.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, one setup cycle, 40 bits, one tail cycle, done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = SHIFT;
            SHIFT: begin
                if (shift_done) begin
                    state_d = TAIL;
                end else if (!shift_busy) begin
                    // Shifter lost its frame (cannot happen in normal operation): recover.
                    state_d = IDLE;
                end
            end
            TAIL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state outputs: frame load on accept, shifter start in SETUP, chip select window.
    always_comb begin
        load      = 1'b0;
        start     = 1'b0;
        frame_act = 1'b0;
        case (state_q)
            IDLE:  load = accept;
            SETUP: begin
                start     = 1'b1;
                frame_act = 1'b1;
            end
            SHIFT: frame_act = 1'b1;
            TAIL:  frame_act = 1'b1;
            default: ;
        endcase
    end

    // Served pulses for the single cycle after DONE, letting the CPU take its step.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            served_q <= 1'b0;
        end else begin
            served_q <= (state_q == DONE);
        end
    end

    // Direction of the access in flight; the CPU is frozen so this only needs capturing once.
    always_ff @(posedge clkin) begin
        if (load) begin
            wr_q <= cpu.rdwr;
        end
    end

    // Read data updates only at the end of a read frame and is cleared by reset.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else if (state_q == DONE && !wr_q) begin
            rdata_q <= shift_rdata;
        end
    end

    assign spi_cs_n  = !frame_act;
    assign spi_mosi  = frame_act && shift_mosi;
    assign cpu.rdata = rdata_q;
    assign cpu.hold  = !rst && (accept || frame_act);

endmodule

// File: tb/tb_cpu_spi_mem_responder.sv
module tb_cpu_spi_mem_responder;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic [1:0]       rst_r;
    logic [1:0]       en_r;
    logic [1:0]       rdwr_r;
    logic [1:0][11:0] addr_r;
    logic [1:0][15:0] wdata_r;

    wire [1:0]        hold_w;
    wire [1:0]        cs_w;
    wire [1:0]        sclk_w;
    wire [1:0]        mosi_w;
    wire [1:0][15:0]  rdata_w;
    wire [1:0][39:0]  frame_w;
    wire [1:0][31:0]  frames_w;
    wire [1:0][31:0]  rises_w;
    wire [1:0][31:0]  gap_w;
    wire [1:0][31:0]  hmin_w;
    wire [1:0][31:0]  hmax_w;
    wire [1:0][31:0]  lmin_w;
    wire [1:0][31:0]  lmax_w;

    int checks = 0;
    int errors = 0;

    // Contents of SRAM locations never written by the bench.
    function automatic logic [15:0] def_word(input logic [15:0] ba);
        case (ba)
            16'h0246: return 16'hBEEF;
            16'h0020: return 16'h0007;
            16'h0000: return 16'hC3A5;
            default:  return ba ^ 16'h5A00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instance 0 runs SCK_HALF=1, instance 1 runs SCK_HALF=3; each has its own SRAM model.
    for (genvar g = 0; g < 2; g++) begin : u
        cpu_spi_mem_responder_if bus();
        logic miso = 1'b0;

        assign bus.en      = en_r[g];
        assign bus.rdwr    = rdwr_r[g];
        assign bus.addr    = addr_r[g];
        assign bus.wdata   = wdata_r[g];
        assign hold_w[g]   = bus.hold;
        assign rdata_w[g]  = bus.rdata;

        cpu_spi_mem_responder #(
            .SCK_HALF ((g == 0) ? 1 : 3)
        ) dut (
            .clkin    (clkin),
            .rst      (rst_r[g]),
            .cpu      (bus.slave),
            .spi_cs_n (cs_w[g]),
            .spi_sclk (sclk_w[g]),
            .spi_mosi (mosi_w[g]),
            .spi_miso (miso)
        );

        logic        prev_cs = 1'b1;
        logic        prev_sclk = 1'b0;
        int          rises = 0, run = 0, frames = 0, hicnt = 0, gap = 0;
        int          hmin = 0, hmax = 0, lmin = 0, lmax = 0;
        logic [39:0] rx = '0, last = '0;
        logic [7:0]  cmd_l = '0;
        logic [15:0] ba_l = '0, rd_word = '0;
        logic [15:0] wmem [int];

        always @(posedge clkin) begin
            if (!cs_w[g] && prev_cs) begin
                rises = 0; rx = '0; run = 1; prev_sclk = 1'b0; cmd_l = '0;
                hmin = 999; hmax = 0; lmin = 999; lmax = 0;
                gap = hicnt; hicnt = 0;
            end else if (!cs_w[g]) begin
                if (sclk_w[g] == prev_sclk) begin
                    run++;
                end else begin
                    if (prev_sclk) begin
                        if (run < hmin) hmin = run;
                        if (run > hmax) hmax = run;
                    end else if (rises > 0) begin
                        if (run < lmin) lmin = run;
                        if (run > lmax) lmax = run;
                    end
                    run = 1;
                    if (sclk_w[g]) begin
                        rx = {rx[38:0], mosi_w[g]};
                        rises++;
                        if (rises == 24) begin
                            cmd_l = rx[23:16];
                            ba_l  = rx[15:0];
                            rd_word = wmem.exists(int'(ba_l)) ? wmem[int'(ba_l)] : def_word(ba_l);
                        end
                    end
                end
                prev_sclk = sclk_w[g];
            end else begin
                hicnt++;
                if (!prev_cs) begin
                    frames++;
                    last = rx;
                    if (cmd_l == 8'h02 && rises == 40) wmem[int'(ba_l)] = rx[15:0];
                end
            end
            prev_cs = cs_w[g];
        end

        always @(negedge sclk_w[g]) begin
            if (!cs_w[g] && cmd_l == 8'h03 && rises >= 24 && rises < 40)
                miso = rd_word[15 - (rises - 24)];
            else
                miso = 1'b0;
        end

        assign frame_w[g]  = last;
        assign frames_w[g] = frames;
        assign rises_w[g]  = rises;
        assign gap_w[g]    = gap;
        assign hmin_w[g]   = hmin;
        assign hmax_w[g]   = hmax;
        assign lmin_w[g]   = lmin;
        assign lmax_w[g]   = lmax;
    end

    // Drive one access (called at a falling edge) and count cycles with hold high.
    task automatic access(input int i, input logic wr, input logic [11:0] a,
                          input logic [15:0] d, input bit b2b, output int cyc);
        rdwr_r[i] = wr; addr_r[i] = a; wdata_r[i] = d; en_r[i] = 1'b1;
        if (b2b) @(negedge clkin);
        #1;
        cyc = 0;
        while (hold_w[i] && cyc < 1000) begin
            cyc++;
            @(negedge clkin);
            #1;
        end
    endtask

    initial begin
        int cyc, f0, n, bad;
        rst_r = 2'b11; en_r = 2'b01; rdwr_r = '0; addr_r = '0; wdata_r = '0;
        repeat (3) @(negedge clkin);
        #1;
        chk("rst_cs_n",  cs_w[0], 1'b1);
        chk("rst_sclk",  sclk_w[0], 1'b0);
        chk("rst_mosi",  mosi_w[0], 1'b0);
        chk("rst_hold",  hold_w[0], 1'b0);
        chk("rst_rdata", rdata_w[0], 16'h0000);
        en_r = 2'b00;
        @(negedge clkin); rst_r = 2'b00;
        @(negedge clkin); #1;
        chk("idle_hold", hold_w[0], 1'b0);

        // Read 12'h123 -> byte 0246, model returns BEEF
        @(negedge clkin);
        access(0, 1'b0, 12'h123, 16'h0000, 1'b0, cyc);
        chk("rd_hold_len", cyc, 84);
        chk("rd_rdata", rdata_w[0], 16'hBEEF);
        chk("rd_frame", frame_w[0], 40'h03_0246_0000);
        en_r[0] = 1'b0;

        // Write A55A to 12'hFFF
        @(negedge clkin);
        access(0, 1'b1, 12'hFFF, 16'hA55A, 1'b0, cyc);
        chk("wr_hold_len", cyc, 84);
        chk("wr_rdata_kept", rdata_w[0], 16'hBEEF);
        chk("wr_frame", frame_w[0], 40'h02_1FFE_A55A);
        en_r[0] = 1'b0;

        @(negedge clkin);
        access(0, 1'b0, 12'hFFF, 16'h0000, 1'b0, cyc);
        chk("rdback_fff", rdata_w[0], 16'hA55A);
        en_r[0] = 1'b0;

        // Back-to-back: read 010 then write 0008 with en held high
        f0 = frames_w[0];
        @(negedge clkin);
        access(0, 1'b0, 12'h010, 16'h0000, 1'b0, cyc);
        chk("b2b_rd_rdata", rdata_w[0], 16'h0007);
        access(0, 1'b1, 12'h010, 16'h0008, 1'b1, cyc);
        chk("b2b_wr_hold_len", cyc, 84);
        chk("b2b_wr_rdata_kept", rdata_w[0], 16'h0007);
        en_r[0] = 1'b0;
        chk("b2b_frames", frames_w[0] - f0, 2);
        chk("b2b_cs_gap_ge2", (gap_w[0] >= 2), 1'b1);
        @(negedge clkin);
        access(0, 1'b0, 12'h010, 16'h0000, 1'b0, cyc);
        chk("b2b_rdback", rdata_w[0], 16'h0008);
        en_r[0] = 1'b0;

        // SCK_HALF=3 read of 12'h000
        @(negedge clkin);
        access(1, 1'b0, 12'h000, 16'h0000, 1'b0, cyc);
        chk("h3_hold_len", cyc, 244);
        chk("h3_rdata", rdata_w[1], 16'hC3A5);
        chk("h3_rises", rises_w[1], 40);
        chk("h3_high_min", hmin_w[1], 3);
        chk("h3_high_max", hmax_w[1], 3);
        chk("h3_low_min", lmin_w[1], 3);
        chk("h3_low_max", lmax_w[1], 3);
        chk("h3_frame", frame_w[1], 40'h03_0000_0000);
        en_r[1] = 1'b0;

        // Reset in the middle of a write
        @(negedge clkin);
        rdwr_r[0] = 1'b1; addr_r[0] = 12'h055; wdata_r[0] = 16'h1111; en_r[0] = 1'b1;
        n = 0;
        while (rises_w[0] < 20 && n < 500) begin
            @(negedge clkin);
            n++;
        end
        chk("rst_mid_reached", (n < 500), 1'b1);
        rst_r[0] = 1'b1;
        #1;
        chk("rst_mid_cs_n", cs_w[0], 1'b1);
        chk("rst_mid_sclk", sclk_w[0], 1'b0);
        chk("rst_mid_hold", hold_w[0], 1'b0);
        chk("rst_mid_rdata", rdata_w[0], 16'h0000);
        en_r[0] = 1'b0;
        @(negedge clkin); rst_r[0] = 1'b0;
        @(negedge clkin);
        access(0, 1'b0, 12'h055, 16'h0000, 1'b0, cyc);
        chk("post_rst_hold_len", cyc, 84);
        chk("post_rst_rdata", rdata_w[0], 16'h5AAA);
        en_r[0] = 1'b0;

        // Idle for 100 cycles
        f0 = frames_w[0];
        bad = 0;
        repeat (100) begin
            @(negedge clkin); #1;
            if (cs_w[0] !== 1'b1 || sclk_w[0] !== 1'b0 || hold_w[0] !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);
        chk("idle_frames", frames_w[0] - f0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
